// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// FSM encodings, decode actions and control-bus bit positions.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN    = 2'd0,
        CTRL_BUBBLE = 2'd1,
        CTRL_WAIT   = 2'd2
    } ctrl_state_e;

    typedef enum logic [2:0] {
        ACT_RUN,
        ACT_FREEZE,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_HAZ
    } ctrl_act_e;

    localparam int CB_PC_WE      = 0;
    localparam int CB_IFID_WE    = 1;
    localparam int CB_IDEX_WE    = 2;
    localparam int CB_EXMEM_WE   = 3;
    localparam int CB_MEMWB_WE   = 4;
    localparam int CB_IFID_FLUSH = 5;
    localparam int CB_IDEX_FLUSH = 6;
    localparam int CB_W          = 7;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/redirect/memory requests in, register enables and perf out.
interface pipe_ctrl_if #(
    parameter int PERF_W = 16
);
    logic              haz_valid;
    logic [1:0]        haz_cycles;
    logic              br_taken;
    logic              mem_req;
    logic              mem_ready;
    logic              pc_we;
    logic              ifid_we;
    logic              idex_we;
    logic              exmem_we;
    logic              memwb_we;
    logic              ifid_flush;
    logic              idex_flush;
    logic [1:0]        ctrl_state;
    logic [PERF_W-1:0] perf_stall;
    logic [PERF_W-1:0] perf_flush;

    modport master (
        output haz_valid, haz_cycles, br_taken, mem_req, mem_ready,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        input  ifid_flush, idex_flush, ctrl_state,
        input  perf_stall, perf_flush
    );

    modport slave (
        input  haz_valid, haz_cycles, br_taken, mem_req, mem_ready,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        output ifid_flush, idex_flush, ctrl_state,
        output perf_stall, perf_flush
    );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer: owns bubble count, memory-wait freeze and
// redirect flush, and drives every pipeline-register enable.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PERF_W = 16
) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave bus
);

    ctrl_state_e     state;
    ctrl_state_e     state_n;
    ctrl_state_e     ret_state;
    ctrl_state_e     ret_n;
    ctrl_state_e     eff;
    ctrl_act_e       act;
    logic [1:0]      bcnt;
    logic [1:0]      bcnt_n;
    logic            freeze;
    logic            hz;
    logic            stall_inc;
    logic            flush_inc;
    logic [CB_W-1:0] cb;

    assign freeze = bus.mem_req & ~bus.mem_ready;
    assign hz     = bus.haz_valid & (bus.haz_cycles != 2'd0);
    // On release from WAIT the saved state decides this very cycle.
    assign eff    = (state == CTRL_WAIT) ? ret_state : state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CTRL_RUN;
            ret_state <= CTRL_RUN;
            bcnt      <= 2'd0;
        end else begin
            state     <= state_n;
            ret_state <= ret_n;
            bcnt      <= bcnt_n;
        end
    end

    always_comb begin
        act       = ACT_RUN;
        state_n   = CTRL_RUN;
        ret_n     = ret_state;
        bcnt_n    = bcnt;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (freeze) begin
            act       = ACT_FREEZE;
            state_n   = CTRL_WAIT;
            stall_inc = 1'b1;
            if (state != CTRL_WAIT) begin
                ret_n = state;
            end
        end else if (bus.br_taken) begin
            act       = ACT_FLUSH;
            bcnt_n    = 2'd0;
            flush_inc = 1'b1;
        end else if (eff == CTRL_BUBBLE) begin
            act       = ACT_BUBBLE;
            stall_inc = 1'b1;
            bcnt_n    = bcnt - 2'd1;
            state_n   = (bcnt == 2'd1) ? CTRL_RUN : CTRL_BUBBLE;
        end else if (hz) begin
            act       = ACT_HAZ;
            stall_inc = 1'b1;
            if (bus.haz_cycles > 2'd1) begin
                bcnt_n  = bus.haz_cycles - 2'd1;
                state_n = CTRL_BUBBLE;
            end
        end
    end

    always_comb begin
        cb = '0;
        if (rst) begin
            cb[CB_IFID_FLUSH] = 1'b1;
            cb[CB_IDEX_FLUSH] = 1'b1;
        end else begin
            unique case (act)
                ACT_FREEZE: cb = '0;
                ACT_FLUSH: begin
                    cb                = '1;
                end
                ACT_BUBBLE, ACT_HAZ: begin
                    cb[CB_IDEX_WE]    = 1'b1;
                    cb[CB_EXMEM_WE]   = 1'b1;
                    cb[CB_MEMWB_WE]   = 1'b1;
                    cb[CB_IDEX_FLUSH] = 1'b1;
                end
                ACT_RUN: begin
                    cb[CB_PC_WE]      = 1'b1;
                    cb[CB_IFID_WE]    = 1'b1;
                    cb[CB_IDEX_WE]    = 1'b1;
                    cb[CB_EXMEM_WE]   = 1'b1;
                    cb[CB_MEMWB_WE]   = 1'b1;
                end
                default: cb = '0;
            endcase
        end
    end

    assign bus.pc_we      = cb[CB_PC_WE];
    assign bus.ifid_we    = cb[CB_IFID_WE];
    assign bus.idex_we    = cb[CB_IDEX_WE];
    assign bus.exmem_we   = cb[CB_EXMEM_WE];
    assign bus.memwb_we   = cb[CB_MEMWB_WE];
    assign bus.ifid_flush = cb[CB_IFID_FLUSH];
    assign bus.idex_flush = cb[CB_IDEX_FLUSH];
    assign bus.ctrl_state = state;

    sat_counter #(.W(PERF_W)) u_perf_stall (
        .clk (clk),
        .inc (stall_inc),
        .clr (rst),
        .q   (bus.perf_stall)
    );

    sat_counter #(.W(PERF_W)) u_perf_flush (
        .clk (clk),
        .inc (flush_inc),
        .clr (rst),
        .q   (bus.perf_flush)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, freeze, redirect, reset,
// and perf-counter saturation on a narrow instance.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.PERF_W(16)) bus ();
    pipe_ctrl_if #(.PERF_W(4))  sbus ();

    pipe_ctrl #(.PERF_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_ctrl #(.PERF_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic hv, input logic [1:0] hc,
                         input logic br, input logic mr,
                         input logic mrdy);
        bus.haz_valid  = hv;
        bus.haz_cycles = hc;
        bus.br_taken   = br;
        bus.mem_req    = mr;
        bus.mem_ready  = mrdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] wes();
        return {bus.memwb_we, bus.exmem_we, bus.idex_we,
                bus.ifid_we, bus.pc_we};
    endfunction

    initial begin
        sbus.haz_valid  = 1'b0;
        sbus.haz_cycles = 2'd0;
        sbus.br_taken   = 1'b0;
        sbus.mem_req    = 1'b0;
        sbus.mem_ready  = 1'b0;

        // reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            chk("rst_we", 32'(wes()), 32'h0);
            chk("rst_ifid_flush", 32'(bus.ifid_flush), 32'h1);
            chk("rst_idex_flush", 32'(bus.idex_flush), 32'h1);
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("rel_state", 32'(bus.ctrl_state), 32'h0);
        chk("rel_pstall", 32'(bus.perf_stall), 32'h0);
        chk("rel_pflush", 32'(bus.perf_flush), 32'h0);
        chk("rel_we", 32'(wes()), 32'h1f);

        // haz_cycles=0 with haz_valid is no hazard
        drive(1, 0, 0, 0, 0);
        chk("n0_pc_we", 32'(bus.pc_we), 32'h1);
        tick();

        // hazard N=3, haz_valid kept high through bubbles
        drive(1, 3, 0, 0, 0);
        chk("n3_c0_pc_we", 32'(bus.pc_we), 32'h0);
        chk("n3_c0_idex_flush", 32'(bus.idex_flush), 32'h1);
        chk("n3_c0_state", 32'(bus.ctrl_state), 32'h0);
        tick();
        chk("n3_c1_pc_we", 32'(bus.pc_we), 32'h0);
        chk("n3_c1_ifid_we", 32'(bus.ifid_we), 32'h0);
        chk("n3_c1_state", 32'(bus.ctrl_state), 32'h1);
        tick();
        chk("n3_c2_pc_we", 32'(bus.pc_we), 32'h0);
        chk("n3_c2_idex_flush", 32'(bus.idex_flush), 32'h1);
        chk("n3_c2_state", 32'(bus.ctrl_state), 32'h1);
        tick();
        drive(0, 0, 0, 0, 0);
        exp_stall += 3;
        chk("n3_c3_pc_we", 32'(bus.pc_we), 32'h1);
        chk("n3_c3_state", 32'(bus.ctrl_state), 32'h0);
        chk("n3_pstall", 32'(bus.perf_stall), 32'(exp_stall));
        tick();

        // hazard N=2 with 4-cycle freeze on bubble cycle
        drive(1, 2, 0, 0, 0);
        chk("n2f_c0_pc_we", 32'(bus.pc_we), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 1, 0);
            chk("n2f_wait_we", 32'(wes()), 32'h0);
            chk("n2f_wait_flush",
                32'({bus.ifid_flush, bus.idex_flush}), 32'h0);
            chk("n2f_wait_state", 32'(bus.ctrl_state),
                (i == 0) ? 32'h1 : 32'h2);
            tick();
        end
        drive(0, 0, 0, 1, 1);
        chk("n2f_rel_state", 32'(bus.ctrl_state), 32'h2);
        chk("n2f_rel_pc_we", 32'(bus.pc_we), 32'h0);
        chk("n2f_rel_idex_flush", 32'(bus.idex_flush), 32'h1);
        chk("n2f_rel_exmem_we", 32'(bus.exmem_we), 32'h1);
        tick();
        drive(0, 0, 0, 0, 0);
        exp_stall += 6;
        chk("n2f_end_state", 32'(bus.ctrl_state), 32'h0);
        chk("n2f_end_pc_we", 32'(bus.pc_we), 32'h1);
        chk("n2f_pstall", 32'(bus.perf_stall), 32'(exp_stall));
        tick();

        // br_taken on 2nd cycle of N=3 bubble
        drive(1, 3, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0);
        chk("brb_state", 32'(bus.ctrl_state), 32'h1);
        chk("brb_pc_we", 32'(bus.pc_we), 32'h1);
        chk("brb_flush",
            32'({bus.ifid_flush, bus.idex_flush}), 32'h3);
        chk("brb_memwb_we", 32'(bus.memwb_we), 32'h1);
        tick();
        drive(0, 0, 0, 0, 0);
        exp_stall += 1;
        exp_flush += 1;
        chk("brb_after_state", 32'(bus.ctrl_state), 32'h0);
        chk("brb_after_pc_we", 32'(bus.pc_we), 32'h1);
        chk("brb_pflush", 32'(bus.perf_flush), 32'(exp_flush));
        chk("brb_pstall", 32'(bus.perf_stall), 32'(exp_stall));
        tick();

        // simultaneous hazard N=2 and br_taken in RUN
        drive(1, 2, 1, 0, 0);
        chk("hbr_pc_we", 32'(bus.pc_we), 32'h1);
        chk("hbr_flush",
            32'({bus.ifid_flush, bus.idex_flush}), 32'h3);
        tick();
        drive(0, 0, 0, 0, 0);
        exp_flush += 1;
        chk("hbr_state", 32'(bus.ctrl_state), 32'h0);
        chk("hbr_pstall", 32'(bus.perf_stall), 32'(exp_stall));
        chk("hbr_pflush", 32'(bus.perf_flush), 32'(exp_flush));
        tick();

        // hazard accepted in release cycle from WAIT (ret RUN)
        drive(0, 0, 0, 1, 0);
        tick();
        tick();
        drive(1, 1, 0, 1, 1);
        chk("wrel_state", 32'(bus.ctrl_state), 32'h2);
        chk("wrel_pc_we", 32'(bus.pc_we), 32'h0);
        chk("wrel_idex_flush", 32'(bus.idex_flush), 32'h1);
        tick();
        drive(0, 0, 0, 0, 0);
        exp_stall += 3;
        chk("wrel_after_state", 32'(bus.ctrl_state), 32'h0);
        chk("wrel_pstall", 32'(bus.perf_stall), 32'(exp_stall));
        tick();

        // reset mid-BUBBLE
        drive(1, 3, 0, 0, 0);
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        chk("rstb_we", 32'(wes()), 32'h0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("rstb_state", 32'(bus.ctrl_state), 32'h0);
        chk("rstb_pc_we", 32'(bus.pc_we), 32'h1);
        chk("rstb_pstall", 32'(bus.perf_stall), 32'h0);
        chk("rstb_pflush", 32'(bus.perf_flush), 32'h0);
        tick();
        chk("rstb_next_pc_we", 32'(bus.pc_we), 32'h1);

        // saturation on the 4-bit instance
        sbus.mem_req   = 1'b1;
        sbus.mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("sat_pstall", 32'(sbus.perf_stall),
                (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        chk("sat_state", 32'(sbus.ctrl_state), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
